led_pattern_ctrl: RTL and testbench



---
 rtl/led_pattern_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// led_pattern_ctrl
//
// LED output peripheral fed by the single-cycle MIPS core's peripheral fields.
// A single command selects a display mode and loads a 16-bit pattern; a
// programmable tick divider then animates the pattern without further
// software involvement.
//
// Modes : 0 STATIC, 1 BLINK, 2 ROT_L, 3 ROT_R
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   cmd_valid  core is executing a peripheral-access instruction this cycle
//   device     target device number (instr[15:11])
//   command    peripheral command code (instr[5:0])
//   data_in    operand from the register file (rt)
//   leds       registered LED drive, 1 = lit
//   mode       current display mode
//   tick       one-cycle pulse at each animation step
//
// Optional build macro:
//   LED_PWM_DIM_EN  adds a 16-step PWM dimmer and command 6'h07 (DIM).
//                   Undefined: 6'h07 is a no-op and leds carry the undimmed
//                   display.
// -----------------------------------------------------------------------------
module led_pattern_ctrl #(
    parameter logic [4:0]        DEVICE_ID    = 5'd1,
    parameter int unsigned       RATE_W       = 24,
    parameter logic [RATE_W-1:0] DEFAULT_RATE = 24'd12_500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [4:0]  device,
    input  logic [5:0]  command,
    input  logic [31:0] data_in,
    output logic [15:0] leds,
    output logic [1:0]  mode,
    output logic        tick
);

    // Command codes
    localparam logic [5:0] CMD_NOP   = 6'h00;
    localparam logic [5:0] CMD_SET   = 6'h01;
    localparam logic [5:0] CMD_BLINK = 6'h02;
    localparam logic [5:0] CMD_ROTL  = 6'h03;
    localparam logic [5:0] CMD_ROTR  = 6'h04;
    localparam logic [5:0] CMD_CLEAR = 6'h05;
    localparam logic [5:0] CMD_RATE  = 6'h06;
`ifdef LED_PWM_DIM_EN
    localparam logic [5:0] CMD_DIM   = 6'h07;
`endif

    // Display modes
    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROT_L  = 2'd2;
    localparam logic [1:0] MODE_ROT_R  = 2'd3;

    localparam logic [RATE_W-1:0] RATE_ONE = {{(RATE_W-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [15:0]       pattern_q;
    logic [1:0]        mode_q;
    logic              phase_q;     // blink phase, 1 = on
    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] div_q;
    logic              tick_q;
    logic [15:0]       leds_q;
`ifdef LED_PWM_DIM_EN
    logic [3:0]        pwm_q;
    logic [3:0]        duty_q;
`endif

    // -------------------------------------------------------------------------
    // Next-state
    // -------------------------------------------------------------------------
    logic              accept;
    logic              div_zero;
    logic              reload;
    logic [RATE_W-1:0] rate_cmd;
    logic [15:0]       pattern_d;
    logic [1:0]        mode_d;
    logic              phase_d;
    logic [RATE_W-1:0] rate_d;
    logic [RATE_W-1:0] div_d;
    logic [15:0]       display_d;
    logic [15:0]       leds_d;
`ifdef LED_PWM_DIM_EN
    logic [3:0]        pwm_d;
    logic [3:0]        duty_d;
`endif

    // Bits of data_in above the rate field are never needed.
    logic unused_data;
    assign unused_data = ^data_in[31:RATE_W];

    always_comb begin
        accept    = cmd_valid && (device == DEVICE_ID);
        div_zero  = (div_q == '0);
        rate_cmd  = (data_in[RATE_W-1:0] == '0) ? RATE_ONE : data_in[RATE_W-1:0];

        reload    = 1'b0;
        pattern_d = pattern_q;
        mode_d    = mode_q;
        phase_d   = phase_q;
        rate_d    = rate_q;
`ifdef LED_PWM_DIM_EN
        duty_d    = duty_q;
`endif

        if (accept) begin
            // Any accepted command suppresses the animation step of a
            // coinciding tick; the tick pulse itself is unaffected.
            case (command)
                CMD_NOP: ;
                CMD_SET: begin
                    pattern_d = data_in[15:0];
                    mode_d    = MODE_STATIC;
                    reload    = 1'b1;
                end
                CMD_BLINK: begin
                    pattern_d = data_in[15:0];
                    mode_d    = MODE_BLINK;
                    phase_d   = 1'b1;
                    reload    = 1'b1;
                end
                CMD_ROTL: begin
                    pattern_d = data_in[15:0];
                    mode_d    = MODE_ROT_L;
                    reload    = 1'b1;
                end
                CMD_ROTR: begin
                    pattern_d = data_in[15:0];
                    mode_d    = MODE_ROT_R;
                    reload    = 1'b1;
                end
                CMD_CLEAR: begin
                    pattern_d = '0;
                    mode_d    = MODE_STATIC;
                    reload    = 1'b1;
                end
                CMD_RATE: begin
                    rate_d = rate_cmd;
                    reload = 1'b1;
                end
`ifdef LED_PWM_DIM_EN
                CMD_DIM: duty_d = data_in[3:0];
`endif
                default: ;
            endcase
        end else if (div_zero) begin
            case (mode_q)
                MODE_BLINK: phase_d   = ~phase_q;
                MODE_ROT_L: pattern_d = {pattern_q[14:0], pattern_q[15]};
                MODE_ROT_R: pattern_d = {pattern_q[0], pattern_q[15:1]};
                default: ;
            endcase
        end

        // A reload uses the post-command rate, so RATE takes effect at once.
        if (reload) begin
            div_d = rate_d - RATE_ONE;
        end else if (div_zero) begin
            div_d = rate_q - RATE_ONE;
        end else begin
            div_d = div_q - RATE_ONE;
        end

        display_d = (mode_d == MODE_BLINK && !phase_d) ? '0 : pattern_d;

`ifdef LED_PWM_DIM_EN
        pwm_d  = pwm_q + 4'd1;
        leds_d = display_d & {16{pwm_d <= duty_d}};
`else
        leds_d = display_d;
`endif
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= '0;
            mode_q    <= MODE_STATIC;
            phase_q   <= 1'b1;
            rate_q    <= DEFAULT_RATE;
            div_q     <= DEFAULT_RATE - RATE_ONE;
            tick_q    <= 1'b0;
            leds_q    <= '0;
`ifdef LED_PWM_DIM_EN
            pwm_q     <= '0;
            duty_q    <= '1;
`endif
        end else begin
            pattern_q <= pattern_d;
            mode_q    <= mode_d;
            phase_q   <= phase_d;
            rate_q    <= rate_d;
            div_q     <= div_d;
            tick_q    <= div_zero;
            leds_q    <= leds_d;
`ifdef LED_PWM_DIM_EN
            pwm_q     <= pwm_d;
            duty_q    <= duty_d;
`endif
        end
    end

    assign leds = leds_q;
    assign mode = mode_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_ctrl
//
// Self-checking bench for led_pattern_ctrl. A behavioural model tracks the
// pattern, mode and blink phase, and derives ticks from the number of edges
// since the last divider reload (a tick on every multiple of the rate).
// DEFAULT_RATE is overridden to a small value so reset timing stays short.
// -----------------------------------------------------------------------------
module tb_led_pattern_ctrl;

    localparam int DEF_RATE = 20;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic [4:0]  device;
    logic [5:0]  command;
    logic [31:0] data_in;
    logic [15:0] leds;
    logic [1:0]  mode;
    logic        tick;

    int errors = 0;
    int checks = 0;

    led_pattern_ctrl #(
        .DEVICE_ID   (5'd1),
        .RATE_W      (24),
        .DEFAULT_RATE(24'd20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .device   (device),
        .command  (command),
        .data_in  (data_in),
        .leds     (leds),
        .mode     (mode),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_pat;
    logic [1:0]  m_mode;
    bit          m_phase;
    int          m_rate;
    int          m_since;   // edges since the last divider reload
    bit          m_tick;
    int          m_duty;
    int          m_edges;   // edges since reset (PWM position)
    logic [15:0] m_leds;

    function automatic void model_outputs();
        logic [15:0] disp;
        disp = (m_mode == 2'd1 && !m_phase) ? 16'h0000 : 16'(m_pat);
`ifdef LED_PWM_DIM_EN
        m_leds = disp & (((m_edges % 16) <= m_duty) ? 16'hFFFF : 16'h0000);
`else
        m_leds = disp;
`endif
    endfunction

    function automatic void model_reset();
        m_pat   = 0;
        m_mode  = 2'd0;
        m_phase = 1'b1;
        m_rate  = DEF_RATE;
        m_since = 0;
        m_tick  = 1'b0;
        m_duty  = 15;
        m_edges = 0;
        model_outputs();
    endfunction

    function automatic void model_edge(input bit v, input logic [4:0] d,
                                       input logic [5:0] c, input logic [31:0] x);
        m_since = m_since + 1;
        m_edges = m_edges + 1;
        m_tick  = (m_since % m_rate) == 0;
        if (v && d == 5'd1) begin
            case (c)
                6'h01: begin m_pat = int'(x[15:0]); m_mode = 2'd0; m_since = 0; end
                6'h02: begin m_pat = int'(x[15:0]); m_mode = 2'd1; m_phase = 1'b1; m_since = 0; end
                6'h03: begin m_pat = int'(x[15:0]); m_mode = 2'd2; m_since = 0; end
                6'h04: begin m_pat = int'(x[15:0]); m_mode = 2'd3; m_since = 0; end
                6'h05: begin m_pat = 0; m_mode = 2'd0; m_since = 0; end
                6'h06: begin
                    m_rate  = (x[23:0] == 24'd0) ? 1 : int'(x[23:0]);
                    m_since = 0;
                end
`ifdef LED_PWM_DIM_EN
                6'h07: m_duty = int'(x[3:0]);
`endif
                default: ;
            endcase
        end else if (m_tick) begin
            if (m_mode == 2'd1) m_phase = !m_phase;
            else if (m_mode == 2'd2) m_pat = ((m_pat << 1) | (m_pat >> 15)) & 16'hFFFF;
            else if (m_mode == 2'd3) m_pat = ((m_pat >> 1) | (m_pat << 15)) & 16'hFFFF;
        end
        model_outputs();
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input bit v, input logic [4:0] d, input logic [5:0] c,
                         input logic [31:0] x);
        cmd_valid = v;
        device    = d;
        command   = c;
        data_in   = x;
        @(posedge clk);
        model_edge(v, d, c, x);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 6'h00, 32'h0);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL reset_leds got=%h exp=0000", leds); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    endtask

    task automatic test_set_static();
        cycle(1'b1, 5'd1, 6'h01, 32'h0000_A5A5);
        checks++; if (leds !== 16'hA5A5) begin errors++; $display("FAIL set_leds got=%h exp=a5a5", leds); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL set_mode got=%0d exp=0", mode); end
        for (int i = 0; i < 100; i++) begin
            idle();
            checks++;
            if (leds !== 16'hA5A5 || leds !== m_leds) begin
                errors++; $display("FAIL static_hold cyc=%0d got=%h exp=a5a5", i, leds);
            end
        end
    endtask

    task automatic test_rotl();
        cycle(1'b1, 5'd1, 6'h06, 32'd4);
        cycle(1'b1, 5'd1, 6'h03, 32'h0000_0001);
        checks++; if (leds !== 16'h0001) begin errors++; $display("FAIL rotl_load got=%h exp=0001", leds); end
        for (int i = 1; i <= 64; i++) begin
            idle();
            checks++;
            if (leds !== m_leds || tick !== m_tick) begin
                errors++; $display("FAIL rotl_step i=%0d got=%h/%b exp=%h/%b", i, leds, tick, m_leds, m_tick);
            end
            if (i == 4) begin
                checks++; if (leds !== 16'h0002) begin errors++; $display("FAIL rotl_first got=%h exp=0002", leds); end
            end
            if (i == 8) begin
                checks++; if (leds !== 16'h0004) begin errors++; $display("FAIL rotl_second got=%h exp=0004", leds); end
            end
            if (i == 64) begin
                checks++; if (leds !== 16'h0001) begin errors++; $display("FAIL rotl_wrap got=%h exp=0001", leds); end
            end
        end
    endtask

    task automatic test_blink();
        logic [15:0] exp_l;
        cycle(1'b1, 5'd1, 6'h06, 32'd3);
        cycle(1'b1, 5'd1, 6'h02, 32'h0000_FFFF);
        checks++; if (leds !== 16'hFFFF || mode !== 2'd1) begin
            errors++; $display("FAIL blink_load got=%h mode=%0d exp=ffff mode=1", leds, mode);
        end
        for (int i = 1; i <= 12; i++) begin
            idle();
            exp_l = ((i / 3) % 2 == 0) ? 16'hFFFF : 16'h0000;
            checks++;
            if (leds !== exp_l || leds !== m_leds || tick !== ((i % 3) == 0)) begin
                errors++; $display("FAIL blink_step i=%0d got=%h/%b exp=%h/%b", i, leds, tick, exp_l, (i % 3) == 0);
            end
        end
    endtask

    task automatic test_ignore();
        cycle(1'b1, 5'd1, 6'h01, 32'h0000_5A5A);
        cycle(1'b1, 5'd2, 6'h01, 32'h0000_FFFF);
        checks++; if (leds !== 16'h5A5A) begin errors++; $display("FAIL ignore_dev got=%h exp=5a5a", leds); end
        cycle(1'b0, 5'd1, 6'h01, 32'h0000_FFFF);
        checks++; if (leds !== 16'h5A5A) begin errors++; $display("FAIL ignore_valid got=%h exp=5a5a", leds); end
        cycle(1'b1, 5'd1, 6'h3F, 32'h0000_FFFF);
        checks++; if (leds !== 16'h5A5A || mode !== 2'd0) begin
            errors++; $display("FAIL ignore_cmd got=%h mode=%0d exp=5a5a mode=0", leds, mode);
        end
    endtask

    task automatic test_rotr_rate0();
        cycle(1'b1, 5'd1, 6'h06, 32'd0);
        cycle(1'b1, 5'd1, 6'h04, 32'h0000_8000);
        checks++; if (leds !== 16'h8000 || mode !== 2'd3) begin
            errors++; $display("FAIL rotr_load got=%h mode=%0d exp=8000 mode=3", leds, mode);
        end
        idle();
        checks++; if (leds !== 16'h4000) begin errors++; $display("FAIL rotr_1 got=%h exp=4000", leds); end
        idle();
        checks++; if (leds !== 16'h2000) begin errors++; $display("FAIL rotr_2 got=%h exp=2000", leds); end
        cycle(1'b1, 5'd1, 6'h01, 32'h0000_1234);
        checks++; if (leds !== 16'h1234 || tick !== 1'b1) begin
            errors++; $display("FAIL set_on_tick got=%h/%b exp=1234/1", leds, tick);
        end
        idle();
        checks++; if (leds !== 16'h1234 || mode !== 2'd0) begin
            errors++; $display("FAIL set_on_tick_hold got=%h mode=%0d exp=1234 mode=0", leds, mode);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        cycle(1'b1, 5'd1, 6'h06, 32'd2);
        cycle(1'b1, 5'd1, 6'h03, 32'h0000_0003);
        for (int i = 0; i < 5; i++) idle();
        do_reset();
        checks++; if (leds !== 16'h0000 || mode !== 2'd0) begin
            errors++; $display("FAIL reset_mid got=%h mode=%0d exp=0000 mode=0", leds, mode);
        end
        seen = 1'b0;
        n = 0;
        while (!seen && n < 5 * DEF_RATE) begin
            idle();
            n++;
            if (tick === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen || n != DEF_RATE) begin
            errors++; $display("FAIL reset_first_tick got=%0d seen=%b exp=%0d", n, seen, DEF_RATE);
        end
    endtask

    task automatic test_dim();
        int lit0;
        int lit15;
        do_reset();
        cycle(1'b1, 5'd1, 6'h01, 32'h0000_FFFF);
        cycle(1'b1, 5'd1, 6'h07, 32'd3);
        lit0  = 0;
        lit15 = 0;
        for (int i = 0; i < 16; i++) begin
            idle();
            checks++;
            if (leds !== m_leds) begin errors++; $display("FAIL dim_step i=%0d got=%h exp=%h", i, leds, m_leds); end
            if (leds[0]) lit0++;
            if (leds[15]) lit15++;
        end
`ifdef LED_PWM_DIM_EN
        checks++; if (lit0 != 4 || lit15 != 4) begin
            errors++; $display("FAIL dim_duty got=%0d,%0d exp=4,4", lit0, lit15);
        end
`else
        checks++; if (lit0 != 16 || lit15 != 16) begin
            errors++; $display("FAIL dim_noop got=%0d,%0d exp=16,16", lit0, lit15);
        end
`endif
    endtask

    task automatic test_random();
        bit          v;
        logic [4:0]  d;
        logic [5:0]  c;
        logic [31:0] x;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 4) == 0) ? 5'd2 : 5'd1;
            c = ($urandom_range(0, 2) == 0) ? 6'h00 : 6'($urandom_range(0, 8));
            x = (c == 6'h06) ? 32'($urandom_range(0, 5)) : $urandom;
            cycle(v, d, c, x);
            checks++;
            if (leds !== m_leds || mode !== m_mode || tick !== m_tick) begin
                errors++;
                $display("FAIL random i=%0d got=%h/%0d/%b exp=%h/%0d/%b", i, leds, mode, tick, m_leds, m_mode, m_tick);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        device    = 5'd0;
        command   = 6'h00;
        data_in   = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_set_static();
        test_rotl();
        test_blink();
        test_ignore();
        test_rotr_rate0();
        test_reset_mid();
        test_dim();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
